// File: rtl/clk_sel_sequencer_pkg.sv
// Shared constants for the clock-select sequencer and the clock-mux wrapper.
// Holds the FSM state codes, the mux select encodings and a counter-width helper.
package clk_sel_sequencer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GATE   = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;
    localparam logic [1:0] ST_UNGATE = 2'd3;

    localparam logic CLK_SEL_A = 1'b0;
    localparam logic CLK_SEL_B = 1'b1;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_sel_sequencer_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on every accepted press (releases produce no pulse).
module btn_debounce
    import clk_sel_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Accept the synchronized level only after it has differed for the full window.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = {CW{1'b0}};
            rise_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/clk_sel_sequencer.sv
// Drives the clock-mux select and output gate so that the select only ever
// moves while the gate is closed: gate -> switch -> ungate per request.
module clk_sel_sequencer
    import clk_sel_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SETTLE_CYCLES   = 16,
    parameter int AUTO_PERIOD     = 0,
    parameter int CNT_W           = 16
) (
    input  logic             CLK100MHZ,
    input  logic             aresetn,
    input  logic             btn_in,
    input  logic             auto_en,
    output logic             clk_sel,
    output logic             clk_ce,
    output logic             busy,
    output logic             switch_done,
    output logic [CNT_W-1:0] switch_count
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    logic             btn_req_s, auto_req_s, req_s;
    logic [1:0]       state_q, state_d;
    logic [15:0]      settle_q, settle_d;
    logic             pending_q, pending_d;
    logic             sel_q, sel_d;
    logic             ce_q, ce_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i (CLK100MHZ),
        .rst_ni(aresetn),
        .btn_i (btn_in),
        .rise_o(btn_req_s)
    );

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int AW = cnt_width(AUTO_PERIOD);
            logic [AW-1:0] auto_cnt_q;

            assign auto_req_s = auto_en && (auto_cnt_q == AW'(AUTO_PERIOD - 1));

            // Free-running period timer, parked at zero while auto-switching is off.
            always_ff @(posedge CLK100MHZ or negedge aresetn) begin
                if (!aresetn) begin
                    auto_cnt_q <= {AW{1'b0}};
                end else if (!auto_en || auto_req_s) begin
                    auto_cnt_q <= {AW{1'b0}};
                end else begin
                    auto_cnt_q <= auto_cnt_q + AW'(1);
                end
            end
        end else begin : g_no_auto
            assign auto_req_s = auto_en & 1'b0;
        end
    endgenerate

    assign req_s = btn_req_s | auto_req_s;

    // Sequencer next-state; all outputs are computed here and registered below.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        pending_d = pending_q;
        sel_d     = sel_q;
        ce_d      = ce_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s || pending_q) begin
                    state_d   = ST_GATE;
                    pending_d = 1'b0;
                    settle_d  = 16'd0;
                    ce_d      = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                pending_d = pending_q | req_s;
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_SWITCH;
                    settle_d = 16'd0;
                    sel_d    = ~sel_q;
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            ST_SWITCH: begin
                pending_d = pending_q | req_s;
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_UNGATE;
                    settle_d = 16'd0;
                    ce_d     = 1'b1;
                    done_d   = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            ST_UNGATE: begin
                // A request landing in the last cycle is still remembered.
                pending_d = pending_q | req_s;
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                settle_d  = 16'd0;
                pending_d = 1'b0;
                ce_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge CLK100MHZ or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            settle_q  <= 16'd0;
            pending_q <= 1'b0;
            sel_q     <= CLK_SEL_A;
            ce_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            ce_q      <= ce_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign clk_sel      = sel_q;
    assign clk_ce       = ce_q;
    assign busy         = busy_q;
    assign switch_done  = done_q;
    assign switch_count = count_q;

endmodule

// File: tb/tb_clk_sel_sequencer.sv
// Directed plus randomized bench for clk_sel_sequencer, checked every cycle
// against a timeline model of request acceptance and sequence phases.
module tb_clk_sel_sequencer;

    localparam int DEB    = 8;
    localparam int S      = 4;
    localparam int AUTO   = 50;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             aresetn;
    logic             btn_in;
    logic             auto_en;
    logic             clk_sel;
    logic             clk_ce;
    logic             busy;
    logic             switch_done;
    logic [CNT_W-1:0] switch_count;

    int n_vec = 0;
    int n_err = 0;
    int ce_lows = 0;
    int dones = 0;

    // Reference model: age of the running sequence (-1 = idle) plus request sources.
    int  m_age;
    bit  m_pend, m_sel, m_deb, m_s1, m_s2, m_pulse;
    int  m_cnt;
    int  m_auto_run;
    bit  m_hist[$];

    clk_sel_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (S),
        .AUTO_PERIOD    (AUTO),
        .CNT_W          (CNT_W)
    ) dut (
        .CLK100MHZ   (clk),
        .aresetn     (aresetn),
        .btn_in      (btn_in),
        .auto_en     (auto_en),
        .clk_sel     (clk_sel),
        .clk_ce      (clk_ce),
        .busy        (busy),
        .switch_done (switch_done),
        .switch_count(switch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_age = -1; m_pend = 1'b0; m_sel = 1'b0; m_deb = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_pulse = 1'b0; m_cnt = 0; m_auto_run = 0;
        m_hist.delete();
    endtask

    // One clock edge of the specification-level behaviour.
    task automatic model_edge(input bit b, input bit a);
        bit r, acc;
        r = m_pulse || (a && (m_auto_run % AUTO == AUTO - 1));
        m_auto_run = a ? m_auto_run + 1 : 0;
        if (m_age >= 0) begin
            if (r) m_pend = 1'b1;
            if (m_age == 2*S) begin
                m_age = -1;
            end else begin
                m_age++;
                if (m_age == S) m_sel = !m_sel;
                if (m_age == 2*S) m_cnt = (m_cnt + 1) % 65536;
            end
        end else if (r || m_pend) begin
            m_age = 0;
            m_pend = 1'b0;
        end
        // A new level is accepted once DEB consecutive synced samples disagree with it.
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        acc = (m_hist.size() == DEB);
        foreach (m_hist[i]) if (m_hist[i] == m_deb) acc = 1'b0;
        m_pulse = acc && !m_deb;
        if (acc) m_deb = !m_deb;
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic step(input bit b, input bit a);
        btn_in = b;
        auto_en = a;
        @(posedge clk);
        model_edge(b, a);
        @(negedge clk);
        chk("clk_ce", clk_ce, (m_age >= 0 && m_age < 2*S) ? 0 : 1);
        chk("clk_sel", clk_sel, m_sel);
        chk("busy", busy, (m_age >= 0) ? 1 : 0);
        chk("switch_done", switch_done, (m_age == 2*S) ? 1 : 0);
        chk("switch_count", switch_count, m_cnt);
        if (clk_ce == 1'b0) ce_lows++;
        if (switch_done == 1'b1) dones++;
    endtask

    // Asserts reset away from any clock edge and checks the outputs respond at once.
    task automatic do_reset();
        btn_in = 1'b0;
        auto_en = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("rst_clk_sel", clk_sel, 0);
        chk("rst_clk_ce", clk_ce, 1);
        chk("rst_busy", busy, 0);
        chk("rst_switch_done", switch_done, 0);
        chk("rst_switch_count", switch_count, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_hold_done", switch_done, 0);
        end
        aresetn = 1'b1;
        m_reset();
    endtask

    task automatic auto_plus_press(input int n);
        for (int i = 1; i <= n; i++) step(i >= 44 && i <= 51, i <= 50);
    endtask

    initial begin
        aresetn = 1'b1;
        btn_in = 1'b0;
        auto_en = 1'b0;
        m_reset();

        // 1: reset before the first clock edge
        do_reset();

        // 2: bouncing button never settles long enough
        for (int i = 0; i < 30; i++) step(((i / 3) % 2) == 0, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        chk("bounce_count", switch_count, 0);
        chk("bounce_ce", clk_ce, 1);

        // 3: one clean press
        ce_lows = 0;
        dones = 0;
        repeat (20) step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);
        chk("press_ce_low_cycles", ce_lows, 2*S);
        chk("press_done_pulses", dones, 1);
        chk("press_count", switch_count, 1);
        chk("press_sel", clk_sel, 1);

        // 4: press lands while an auto sequence is busy -> queued second sequence
        do_reset();
        auto_plus_press(100);
        chk("queued_count", switch_count, 2);
        chk("queued_sel", clk_sel, 0);

        // 5: periodic auto switching, then disabled
        do_reset();
        repeat (500) step(1'b0, 1'b1);
        repeat (30) step(1'b0, 1'b0);
        chk("auto_count", switch_count, 10);
        chk("auto_sel", clk_sel, 0);

        // 6: reset in SWITCH with a request pending
        do_reset();
        auto_plus_press(55);
        chk("pre_rst_sel", clk_sel, 1);
        chk("pre_rst_busy", busy, 1);
        do_reset();
        repeat (40) step(1'b0, 1'b0);
        chk("post_rst_count", switch_count, 0);
        chk("post_rst_ce", clk_ce, 1);

        // Randomized button and auto-enable segments
        for (int seg = 0; seg < 40; seg++) begin
            int len;
            bit b, a;
            len = $urandom_range(1, 24);
            b = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0);
            repeat (len) step(b, a);
        end
        repeat (30) step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
